// File: rtl/channel_mixer_if.sv
// Channel-sample input stream and frame-result output bundle for channel_mixer.
interface channel_mixer_if #(
    parameter int CHAN_WIDTH   = 15,
    parameter int SAMPLE_WIDTH = 16,
    parameter int NUM_SPEAKERS = 4,
    parameter int NUM_OUTPUTS  = 2
);
    logic                                  sample_clk_en;
    logic                                  in_valid;
    logic                                  in_ready;
    logic signed [CHAN_WIDTH-1:0]          in_sample;
    logic [NUM_SPEAKERS-1:0]               in_spk_en;
    logic                                  in_last;
    logic [1:0]                            master_shift;
    logic                                  out_valid;
    logic [NUM_OUTPUTS*SAMPLE_WIDTH-1:0]   out_sample;
    logic [NUM_OUTPUTS-1:0]                out_clip;
    logic                                  frame_error;

    // Producer side: operator-combining logic feeding the mixer.
    modport master (
        output sample_clk_en, in_valid, in_sample, in_spk_en, in_last, master_shift,
        input  in_ready, out_valid, out_sample, out_clip, frame_error
    );

    // Mixer side.
    modport slave (
        input  sample_clk_en, in_valid, in_sample, in_spk_en, in_last, master_shift,
        output in_ready, out_valid, out_sample, out_clip, frame_error
    );
endinterface

// File: rtl/channel_mixer.sv
// OPL3 channel mixer: routes per-channel samples to speakers, folds speakers
// onto DAC buses, then shifts, saturates and publishes one frame per period.
module channel_mixer #(
    parameter int CHAN_WIDTH   = 15,
    parameter int SAMPLE_WIDTH = 16,
    parameter int NUM_CHANNELS = 18,
    parameter int NUM_SPEAKERS = 4,
    parameter int NUM_OUTPUTS  = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    channel_mixer_if.slave bus
);
    localparam int ACC_WIDTH = CHAN_WIDTH + $clog2(NUM_CHANNELS * NUM_SPEAKERS / NUM_OUTPUTS) + 1;
    localparam int CNT_WIDTH = $clog2(NUM_CHANNELS + 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (SAMPLE_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]        LAST_BEAT = CNT_WIDTH'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;

    state_t                       state, state_next;
    logic signed [ACC_WIDTH-1:0]  acc   [NUM_OUTPUTS];
    logic signed [ACC_WIDTH-1:0]  addend[NUM_OUTPUTS];
    logic [SAMPLE_WIDTH:0]        sat_res[NUM_OUTPUTS];
    logic [CNT_WIDTH-1:0]         beat_cnt;
    logic                         frame_error_next;
    logic                         accept;
    logic                         closing;
    logic signed [ACC_WIDTH-1:0]  sample_ext;

    // Clamp a shifted accumulator to the bus range; MSB of the result is the clip flag.
    function automatic logic [SAMPLE_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)
            return {1'b1, SAT_MAX[SAMPLE_WIDTH-1:0]};
        else if (v < SAT_MIN)
            return {1'b1, SAT_MIN[SAMPLE_WIDTH-1:0]};
        else
            return {1'b0, v[SAMPLE_WIDTH-1:0]};
    endfunction

    assign accept     = bus.in_valid && bus.in_ready;
    assign closing    = accept && (bus.in_last || (beat_cnt == LAST_BEAT));
    assign sample_ext = {{(ACC_WIDTH-CHAN_WIDTH){bus.in_sample[CHAN_WIDTH-1]}}, bus.in_sample};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; the period strobe overrides every state.
    always_comb begin
        state_next = state;
        if (bus.sample_clk_en) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (closing) state_next = LATCH;
                LATCH:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: beats are only taken while accumulating and never alongside the strobe.
    always_comb begin
        bus.in_ready = (state == ACCUM) && !bus.sample_clk_en;
    end

    // Per-bus contribution of this beat: the sample once for every enabled speaker on that bus.
    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            addend[o] = '0;
            for (int s = 0; s < NUM_SPEAKERS; s++) begin
                if ((s % NUM_OUTPUTS) == o && bus.in_spk_en[s])
                    addend[o] = addend[o] + sample_ext;
            end
        end
    end

    // Master attenuation followed by saturation, evaluated for the LATCH cycle.
    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++)
            sat_res[o] = saturate(acc[o] >>> bus.master_shift);
    end

    // Accumulators, beat counter and registered frame result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < NUM_OUTPUTS; o++)
                acc[o] <= '0;
            beat_cnt         <= '0;
            frame_error_next <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_sample   <= '0;
            bus.out_clip     <= '0;
            bus.frame_error  <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.sample_clk_en) begin
                for (int o = 0; o < NUM_OUTPUTS; o++)
                    acc[o] <= '0;
                beat_cnt <= '0;
            end else if (accept) begin
                for (int o = 0; o < NUM_OUTPUTS; o++)
                    acc[o] <= acc[o] + addend[o];
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                if (closing)
                    frame_error_next <= !(bus.in_last && (beat_cnt == LAST_BEAT));
            end else if (state == LATCH) begin
                for (int o = 0; o < NUM_OUTPUTS; o++) begin
                    bus.out_sample[o*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= sat_res[o][SAMPLE_WIDTH-1:0];
                    bus.out_clip[o] <= sat_res[o][SAMPLE_WIDTH];
                end
                bus.frame_error <= frame_error_next;
                bus.out_valid   <= 1'b1;
            end
        end
    end
endmodule
